mcycle_ctrl: RTL and testbench
==============================

MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 32, datapath word width; it has no effect on control port widths and is kept for instantiation uniformity.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port opcode, input, 6, instruction-register opcode field, sampled in ID.
REQ-005 The block SHALL have port funct, input, 6, instruction-register funct field, sampled in ID.
REQ-006 The block SHALL have port alu_zero, input, 1, ALU zero flag, used in EX.
REQ-007 The block SHALL have ports im_ready and dm_ready, input, 1 each, memory completion strobes.
REQ-008 The block SHALL have ports im_req, dm_req, dm_we, ir_we, pc_we and reg_we, output, 1 each, memory requests and write enables.
REQ-009 The block SHALL have port sel_regdst, output, 2: 00 rt, 01 rd, 10 $ra.
REQ-010 The block SHALL have port sel_alusrc, output, 1: 0 register, 1 immediate.
REQ-011 The block SHALL have port sel_wb, output, 2: 00 ALU out, 01 DM, 10 PC+4.
REQ-012 The block SHALL have port npc_sel, output, 2: 00 PC+4, 01 branch, 10 jump, 11 register (jr).
REQ-013 The block SHALL have ports alu_op, output, 3 (000 ADD, 001 SUB, 010 OR, 011 LUI), and ext_op, output, 1 (0 zero-extend, 1 sign-extend).
REQ-014 The block SHALL have ports state, output, 3, current state; illegal, output, 1; and done, output, 1.

Function
REQ-015 The block SHALL implement the states IF=0, ID=1, EX=2, MEM=3 and WB=4; codes 5-7 SHALL go to IF on the next cycle with all enables low.
REQ-016 In ID the block SHALL latch an instruction class from opcode/funct: ADDU (000000/100001), SUBU (000000/100011), JR (000000/001000), ORI 001101, LUI 001111, LW 100011, SW 101011, BEQ 000100, J 000010, JAL 000011; all other combinations SHALL be ILLEGAL.
REQ-017 In EX, MEM and WB all outputs SHALL be combinational from state, latched class, alu_zero and the ready inputs; in ID the outputs SHALL use the live decode.
REQ-018 In IF: im_req=1; while im_ready=0 the block SHALL hold IF; when im_ready=1 it SHALL assert ir_we=1, pc_we=1 and npc_sel=00, then go to ID.
REQ-019 In ID for J: pc_we=1, npc_sel=10, done=1, then go to IF.
REQ-020 In ID for JAL: pc_we=1, npc_sel=10, reg_we=1, sel_regdst=10, sel_wb=10, done=1, then go to IF.
REQ-021 In ID for JR: pc_we=1, npc_sel=11, done=1, then go to IF.
REQ-022 In ID for ILLEGAL: illegal=1 for one cycle, done=1, no write enables, then go to IF.
REQ-023 In ID for any other class the block SHALL go to EX.
REQ-024 In EX: ADDU and SUBU SHALL drive sel_alusrc=0 with alu_op ADD or SUB respectively.
REQ-025 In EX: ORI SHALL drive sel_alusrc=1, alu_op=OR, ext_op=0; LUI SHALL drive sel_alusrc=1, alu_op=LUI.
REQ-026 In EX: LW and SW SHALL drive sel_alusrc=1, alu_op=ADD, ext_op=1.
REQ-027 In EX: ALU classes SHALL go to WB; LW and SW SHALL go to MEM.
REQ-028 In EX for BEQ: sel_alusrc=0, alu_op=SUB, ext_op=1; pc_we=alu_zero with npc_sel=01; done=1; then go to IF.
REQ-029 In MEM: dm_req=1, and dm_we=1 for SW; the block SHALL hold MEM while dm_ready=0.
REQ-030 In MEM when dm_ready=1: SW SHALL assert done=1 and go to IF; LW SHALL go to WB.
REQ-031 In WB: reg_we=1 and done=1, then go to IF.
REQ-032 In WB: ADDU and SUBU SHALL write with sel_regdst=01, sel_wb=00; ORI and LUI with sel_regdst=00, sel_wb=00; LW with sel_regdst=00, sel_wb=01.
REQ-033 Unlisted outputs SHALL be 0 in every state.
REQ-034 Minimum cycles with zero wait states SHALL be: J/JAL/JR/ILLEGAL 2, BEQ 3, ALU and SW 4, LW 5; each ready-low cycle adds exactly 1.
REQ-035 done SHALL pulse exactly once per instruction, in its final cycle.

Reset
REQ-036 When rst=1 at a clock edge, the next state SHALL be IF and the latched class SHALL be cleared to ILLEGAL.
REQ-037 While rst=1, all enables, requests, illegal and done SHALL be 0 and all selects 0, overriding state, in any state, including reset asserted during MEM or a wait.
REQ-038 The first cycle after rst deasserts SHALL be IF with im_req=1.

Verification
REQ-039 ADDU (000000/100001), ready always 1 -> states IF,ID,EX,WB; WB shows reg_we=1, sel_regdst=01, sel_wb=00, done=1; 4 cycles.
REQ-040 LW with dm_ready low for 2 cycles -> MEM held 3 cycles with dm_req=1, dm_we=0; then WB with sel_wb=01, sel_regdst=00; 7 cycles total.
REQ-041 BEQ with alu_zero=1, then again with alu_zero=0 -> EX pc_we=1, npc_sel=01 in the first case; pc_we=0 in the second; 3 cycles each.
REQ-042 JAL -> ID asserts pc_we=1, npc_sel=10, reg_we=1, sel_regdst=10, sel_wb=10; then IF.
REQ-043 Opcode 111111 -> illegal=1 and done=1 in ID, no write enables, then IF.
REQ-044 SW with rst=1 pulsed during MEM wait -> next cycle IF, dm_we=0, no done pulse for the aborted SW.

Source files
------------

// File: rtl/mcycle_ctrl_if.sv
// Control bundle between the multi-cycle controller (master) and the
// datapath/memory side (slave): decode fields and strobes in, enables and selects out.
interface mcycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       im_ready;
  logic       dm_ready;

  logic       im_req;
  logic       dm_req;
  logic       dm_we;
  logic       ir_we;
  logic       pc_we;
  logic       reg_we;
  logic [1:0] sel_regdst;
  logic       sel_alusrc;
  logic [1:0] sel_wb;
  logic [1:0] npc_sel;
  logic [2:0] alu_op;
  logic       ext_op;
  logic [2:0] state;
  logic       illegal;
  logic       done;

  modport master (
    input  opcode, funct, alu_zero, im_ready, dm_ready,
    output im_req, dm_req, dm_we, ir_we, pc_we, reg_we,
           sel_regdst, sel_alusrc, sel_wb, npc_sel, alu_op, ext_op,
           state, illegal, done
  );

  modport slave (
    output opcode, funct, alu_zero, im_ready, dm_ready,
    input  im_req, dm_req, dm_we, ir_we, pc_we, reg_we,
           sel_regdst, sel_alusrc, sel_wb, npc_sel, alu_op, ext_op,
           state, illegal, done
  );
endinterface

// File: rtl/mcycle_ctrl.sv
// Multi-cycle MIPS-subset controller: IF/ID/EX/MEM/WB sequencer with
// instruction class latched in ID and combinational control outputs.
module mcycle_ctrl #(
  parameter int WORD_WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  mcycle_ctrl_if.master bus
);

  // Word width does not shape any control port; only sanity-checked here.
  if (WORD_WIDTH < 1) begin : g_bad_word_width
  end

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ILLEGAL,
    C_ADDU,
    C_SUBU,
    C_JR,
    C_ORI,
    C_LUI,
    C_LW,
    C_SW,
    C_BEQ,
    C_J,
    C_JAL
  } cls_t;

  typedef struct packed {
    logic       im_req;
    logic       dm_req;
    logic       dm_we;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic [1:0] sel_regdst;
    logic       sel_alusrc;
    logic [1:0] sel_wb;
    logic [1:0] npc_sel;
    logic [2:0] alu_op;
    logic       ext_op;
    logic       illegal;
    logic       done;
  } ctl_t;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_RA    = 2'b10;
  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_DM    = 2'b01;
  localparam logic [1:0] WB_PC4   = 2'b10;
  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;
  localparam logic [1:0] NPC_REG  = 2'b11;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b011;

  state_t state_q;
  state_t state_d;
  cls_t   cls_q;
  cls_t   dec;
  ctl_t   ctl;

  // Live decode of the instruction register; only consumed while in ID.
  always_comb begin
    dec = C_ILLEGAL;
    case (bus.opcode)
      6'b000000: begin
        case (bus.funct)
          6'b100001: dec = C_ADDU;
          6'b100011: dec = C_SUBU;
          6'b001000: dec = C_JR;
          default:   dec = C_ILLEGAL;
        endcase
      end
      6'b001101: dec = C_ORI;
      6'b001111: dec = C_LUI;
      6'b100011: dec = C_LW;
      6'b101011: dec = C_SW;
      6'b000100: dec = C_BEQ;
      6'b000010: dec = C_J;
      6'b000011: dec = C_JAL;
      default:   dec = C_ILLEGAL;
    endcase
  end

  // NOTE: every output and the next state get a default before the case so
  // no path leaves them unassigned, which would otherwise infer latches.
  always_comb begin
    ctl     = '0;
    state_d = S_IF;
    case (state_q)
      S_IF: begin
        ctl.im_req = 1'b1;
        state_d    = S_IF;
        if (bus.im_ready) begin
          ctl.ir_we   = 1'b1;
          ctl.pc_we   = 1'b1;
          ctl.npc_sel = NPC_SEQ;
          state_d     = S_ID;
        end
      end

      S_ID: begin
        case (dec)
          C_J: begin
            ctl.pc_we   = 1'b1;
            ctl.npc_sel = NPC_JMP;
            ctl.done    = 1'b1;
          end
          C_JAL: begin
            ctl.pc_we      = 1'b1;
            ctl.npc_sel    = NPC_JMP;
            ctl.reg_we     = 1'b1;
            ctl.sel_regdst = RD_RA;
            ctl.sel_wb     = WB_PC4;
            ctl.done       = 1'b1;
          end
          C_JR: begin
            ctl.pc_we   = 1'b1;
            ctl.npc_sel = NPC_REG;
            ctl.done    = 1'b1;
          end
          C_ILLEGAL: begin
            ctl.illegal = 1'b1;
            ctl.done    = 1'b1;
          end
          default: state_d = S_EX;
        endcase
      end

      S_EX: begin
        case (cls_q)
          C_ADDU: begin
            ctl.alu_op = ALU_ADD;
            state_d    = S_WB;
          end
          C_SUBU: begin
            ctl.alu_op = ALU_SUB;
            state_d    = S_WB;
          end
          C_ORI: begin
            ctl.sel_alusrc = 1'b1;
            ctl.alu_op     = ALU_OR;
            state_d        = S_WB;
          end
          C_LUI: begin
            ctl.sel_alusrc = 1'b1;
            ctl.alu_op     = ALU_LUI;
            state_d        = S_WB;
          end
          C_LW, C_SW: begin
            ctl.sel_alusrc = 1'b1;
            ctl.alu_op     = ALU_ADD;
            ctl.ext_op     = 1'b1;
            state_d        = S_MEM;
          end
          C_BEQ: begin
            ctl.alu_op  = ALU_SUB;
            ctl.ext_op  = 1'b1;
            ctl.pc_we   = bus.alu_zero;
            ctl.npc_sel = NPC_BR;
            ctl.done    = 1'b1;
          end
          default: state_d = S_IF;
        endcase
      end

      S_MEM: begin
        if (cls_q == C_LW || cls_q == C_SW) begin
          ctl.dm_req = 1'b1;
          ctl.dm_we  = (cls_q == C_SW);
          state_d    = S_MEM;
          if (bus.dm_ready) begin
            if (cls_q == C_SW) begin
              ctl.done = 1'b1;
              state_d  = S_IF;
            end else begin
              state_d = S_WB;
            end
          end
        end
      end

      S_WB: begin
        ctl.reg_we = 1'b1;
        ctl.done   = 1'b1;
        case (cls_q)
          C_ADDU, C_SUBU: begin
            ctl.sel_regdst = RD_RD;
            ctl.sel_wb     = WB_ALU;
          end
          C_LW: begin
            ctl.sel_regdst = RD_RT;
            ctl.sel_wb     = WB_DM;
          end
          default: begin
            ctl.sel_regdst = RD_RT;
            ctl.sel_wb     = WB_ALU;
          end
        endcase
      end

      // Codes 5-7 fall through with all outputs low and recover to IF.
      default: state_d = S_IF;
    endcase

    // Reset masks every output regardless of the state it interrupts.
    if (rst) ctl = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      cls_q   <= C_ILLEGAL;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) cls_q <= dec;
    end
  end

  assign bus.im_req     = ctl.im_req;
  assign bus.dm_req     = ctl.dm_req;
  assign bus.dm_we      = ctl.dm_we;
  assign bus.ir_we      = ctl.ir_we;
  assign bus.pc_we      = ctl.pc_we;
  assign bus.reg_we     = ctl.reg_we;
  assign bus.sel_regdst = ctl.sel_regdst;
  assign bus.sel_alusrc = ctl.sel_alusrc;
  assign bus.sel_wb     = ctl.sel_wb;
  assign bus.npc_sel    = ctl.npc_sel;
  assign bus.alu_op     = ctl.alu_op;
  assign bus.ext_op     = ctl.ext_op;
  assign bus.illegal    = ctl.illegal;
  assign bus.done       = ctl.done;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Scoreboard bench for mcycle_ctrl: stimulus pushes the hand-written per-cycle
// output vector it expects; a negedge monitor pops and compares.
module tb_mcycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mcycle_ctrl_if bus ();

  mcycle_ctrl #(.WORD_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       im_req;
    logic       dm_req;
    logic       dm_we;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic [1:0] regdst;
    logic       alusrc;
    logic [1:0] wb;
    logic [1:0] npc;
    logic [2:0] aluop;
    logic       ext;
    logic       illegal;
    logic       done;
  } outv_t;

  typedef struct {
    string tag;
    outv_t v;
  } exp_t;

  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4;
  localparam logic [5:0] NOISE = 6'b111111;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input outv_t act, input outv_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (st=%0d/%0d)", name, act, exp, act.st, exp.st);
    end
  endtask

  function automatic outv_t sample();
    outv_t a;
    a.st      = bus.state;
    a.im_req  = bus.im_req;
    a.dm_req  = bus.dm_req;
    a.dm_we   = bus.dm_we;
    a.ir_we   = bus.ir_we;
    a.pc_we   = bus.pc_we;
    a.reg_we  = bus.reg_we;
    a.regdst  = bus.sel_regdst;
    a.alusrc  = bus.sel_alusrc;
    a.wb      = bus.sel_wb;
    a.npc     = bus.npc_sel;
    a.aluop   = bus.alu_op;
    a.ext     = bus.ext_op;
    a.illegal = bus.illegal;
    a.done    = bus.done;
    return a;
  endfunction

  // Monitor: one expected vector per clock cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      check(x.tag, sample(), x.v);
    end
  end

  function automatic outv_t z(input logic [2:0] st);
    outv_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  // Inputs set just after the edge hold for the whole cycle being checked.
  task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                      input logic imr, input logic dmr, input logic az, input logic r,
                      input outv_t e);
    exp_t x;
    @(posedge clk);
    #1;
    bus.opcode   = op;
    bus.funct    = fn;
    bus.im_ready = imr;
    bus.dm_ready = dmr;
    bus.alu_zero = az;
    rst          = r;
    x.tag = tag;
    x.v   = e;
    sb.push_back(x);
  endtask

  task automatic fetch(input string tag, input int waits);
    outv_t e;
    e = z(S_IF);
    e.im_req = 1'b1;
    for (int i = 0; i < waits; i++) step({tag, "_if_wait"}, NOISE, NOISE, 1'b0, 1'b1, 1'b0, 1'b0, e);
    e.ir_we = 1'b1;
    e.pc_we = 1'b1;
    step({tag, "_if"}, NOISE, NOISE, 1'b1, 1'b1, 1'b0, 1'b0, e);
  endtask

  task automatic run_alu(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [2:0] aluop, input logic alusrc, input logic [1:0] regdst);
    outv_t e;
    fetch(tag, 0);
    step({tag, "_id"}, op, fn, 1'b1, 1'b1, 1'b0, 1'b0, z(S_ID));
    e = z(S_EX);
    e.aluop  = aluop;
    e.alusrc = alusrc;
    step({tag, "_ex"}, NOISE, NOISE, 1'b1, 1'b1, 1'b0, 1'b0, e);
    e = z(S_WB);
    e.reg_we = 1'b1;
    e.regdst = regdst;
    e.done   = 1'b1;
    step({tag, "_wb"}, NOISE, NOISE, 1'b1, 1'b1, 1'b0, 1'b0, e);
  endtask

  // Fetch, decode, address phase and MEM waits shared by LW and SW.
  task automatic run_mem(input string tag, input logic is_sw, input int dm_waits);
    outv_t e;
    fetch(tag, 0);
    step({tag, "_id"}, is_sw ? 6'b101011 : 6'b100011, NOISE, 1'b1, 1'b1, 1'b0, 1'b0, z(S_ID));
    e = z(S_EX);
    e.alusrc = 1'b1;
    e.ext    = 1'b1;
    step({tag, "_ex"}, NOISE, NOISE, 1'b1, 1'b1, 1'b0, 1'b0, e);
    e = z(S_MEM);
    e.dm_req = 1'b1;
    e.dm_we  = is_sw;
    for (int i = 0; i < dm_waits; i++) step({tag, "_mem_wait"}, NOISE, NOISE, 1'b1, 1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic run_beq(input string tag, input logic az);
    outv_t e;
    fetch(tag, 0);
    step({tag, "_id"}, 6'b000100, NOISE, 1'b1, 1'b1, 1'b0, 1'b0, z(S_ID));
    e = z(S_EX);
    e.aluop = 3'b001;
    e.ext   = 1'b1;
    e.pc_we = az;
    e.npc   = 2'b01;
    e.done  = 1'b1;
    step({tag, "_ex"}, NOISE, NOISE, 1'b1, 1'b1, az, 1'b0, e);
  endtask

  task automatic run_short(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int if_waits, input outv_t eid);
    fetch(tag, if_waits);
    step({tag, "_id"}, op, fn, 1'b1, 1'b1, 1'b0, 1'b0, eid);
  endtask

  initial begin
    outv_t e;
    rst          = 1'b1;
    bus.opcode   = NOISE;
    bus.funct    = NOISE;
    bus.im_ready = 1'b1;
    bus.dm_ready = 1'b1;
    bus.alu_zero = 1'b0;

    // Held reset: IF with every output low even though im_ready is high.
    step("reset0", NOISE, NOISE, 1'b1, 1'b1, 1'b0, 1'b1, z(S_IF));
    step("reset1", NOISE, NOISE, 1'b1, 1'b1, 1'b0, 1'b1, z(S_IF));

    run_alu("addu", 6'b000000, 6'b100001, 3'b000, 1'b0, 2'b01);
    run_alu("subu", 6'b000000, 6'b100011, 3'b001, 1'b0, 2'b01);
    run_alu("ori",  6'b001101, NOISE,     3'b010, 1'b1, 2'b00);
    run_alu("lui",  6'b001111, NOISE,     3'b011, 1'b1, 2'b00);

    // LW with two dm_ready-low cycles: MEM lasts three cycles, seven in total.
    run_mem("lw", 1'b0, 2);
    e = z(S_MEM);
    e.dm_req = 1'b1;
    step("lw_mem", NOISE, NOISE, 1'b1, 1'b1, 1'b0, 1'b0, e);
    e = z(S_WB);
    e.reg_we = 1'b1;
    e.wb     = 2'b01;
    e.done   = 1'b1;
    step("lw_wb", NOISE, NOISE, 1'b1, 1'b1, 1'b0, 1'b0, e);

    // SW with zero waits: completes in MEM.
    run_mem("sw", 1'b1, 0);
    e = z(S_MEM);
    e.dm_req = 1'b1;
    e.dm_we  = 1'b1;
    e.done   = 1'b1;
    step("sw_mem", NOISE, NOISE, 1'b1, 1'b1, 1'b0, 1'b0, e);

    run_beq("beq_taken", 1'b1);
    run_beq("beq_not_taken", 1'b0);

    e = z(S_ID);
    e.pc_we = 1'b1;
    e.npc   = 2'b10;
    e.done  = 1'b1;
    run_short("j", 6'b000010, NOISE, 1, e);

    e = z(S_ID);
    e.pc_we  = 1'b1;
    e.npc    = 2'b10;
    e.reg_we = 1'b1;
    e.regdst = 2'b10;
    e.wb     = 2'b10;
    e.done   = 1'b1;
    run_short("jal", 6'b000011, NOISE, 0, e);

    e = z(S_ID);
    e.pc_we = 1'b1;
    e.npc   = 2'b11;
    e.done  = 1'b1;
    run_short("jr", 6'b000000, 6'b001000, 0, e);

    e = z(S_ID);
    e.illegal = 1'b1;
    e.done    = 1'b1;
    run_short("illegal_op", 6'b111111, NOISE, 0, e);
    run_short("illegal_funct", 6'b000000, 6'b000000, 0, e);

    // SW aborted by reset while waiting on data memory.
    run_mem("sw_abort", 1'b1, 1);
    step("sw_abort_rst", NOISE, NOISE, 1'b1, 1'b0, 1'b0, 1'b1, z(S_MEM));
    e = z(S_ID);
    e.pc_we = 1'b1;
    e.npc   = 2'b10;
    e.done  = 1'b1;
    run_short("after_abort_j", 6'b000010, NOISE, 0, e);

    // One more ALU op proves the controller resumes normally.
    run_alu("addu_end", 6'b000000, 6'b100001, 3'b000, 1'b0, 2'b01);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
